// File: rtl/alu32_result_buffer.sv
// Result buffer behind the 32-bit add/sub ALU: a first-word-fall-through FIFO of {sub_add, carry, zero, overflow, result}.
// Define ALU32_RB_STICKY_EN to build the sticky carry/overflow flags and the saturating overflow counter.
module alu32_result_buffer #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sub_add,
  input  logic [W-1:0]             in_result,
  input  logic                     in_carry,
  input  logic                     in_zero,
  input  logic                     in_overflow,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sub_add,
  output logic                     out_carry,
  output logic                     out_zero,
  output logic                     out_overflow,
  output logic [W-1:0]             out_result,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     clear_sticky,
  output logic                     sticky_carry,
  output logic                     sticky_ovf,
  output logic [7:0]               ovf_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = W + 4;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_head;

  assign in_ready  = (r_count != FULL);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign count     = r_count;

  // Storage is deliberately left unreset; empty reads are masked below.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_sub_add, in_carry, in_zero, in_overflow, in_result};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head       = out_valid ? r_mem[r_rd_ptr] : '0;
  assign out_sub_add  = w_head[W+3];
  assign out_carry    = w_head[W+2];
  assign out_zero     = w_head[W+1];
  assign out_overflow = w_head[W];
  assign out_result   = w_head[W-1:0];

`ifdef ALU32_RB_STICKY_EN
  logic       r_sticky_carry;
  logic       r_sticky_ovf;
  logic [7:0] r_ovf_count;
  logic       w_push_ovf;
  logic       w_push_carry;

  assign w_push_ovf   = w_push && in_overflow;
  assign w_push_carry = w_push && in_carry;

  // A flagged push in the same cycle as a clear survives the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky_carry <= 1'b0;
      r_sticky_ovf   <= 1'b0;
      r_ovf_count    <= '0;
    end else if (clear_sticky) begin
      r_sticky_carry <= w_push_carry;
      r_sticky_ovf   <= w_push_ovf;
      r_ovf_count    <= w_push_ovf ? 8'd1 : 8'd0;
    end else begin
      r_sticky_carry <= r_sticky_carry | w_push_carry;
      r_sticky_ovf   <= r_sticky_ovf | w_push_ovf;
      if (w_push_ovf && (r_ovf_count != 8'hFF)) r_ovf_count <= r_ovf_count + 8'd1;
    end
  end

  assign sticky_carry = r_sticky_carry;
  assign sticky_ovf   = r_sticky_ovf;
  assign ovf_count    = r_ovf_count;
`else
  logic w_unused_clear;
  assign w_unused_clear = clear_sticky;
  assign sticky_carry   = 1'b0;
  assign sticky_ovf     = 1'b0;
  assign ovf_count      = 8'd0;
`endif

endmodule

// File: tb/tb_alu32_result_buffer.sv
// Directed bench for alu32_result_buffer; sticky expectations follow ALU32_RB_STICKY_EN.
module tb_alu32_result_buffer;

`ifdef ALU32_RB_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sub_add;
  logic [31:0] in_result;
  logic        in_carry;
  logic        in_zero;
  logic        in_overflow;
  logic        out_valid;
  logic        out_ready;
  logic        out_sub_add;
  logic        out_carry;
  logic        out_zero;
  logic        out_overflow;
  logic [31:0] out_result;
  logic [2:0]  count;
  logic        clear_sticky;
  logic        sticky_carry;
  logic        sticky_ovf;
  logic [7:0]  ovf_count;

  int checks = 0;
  int errors = 0;

  alu32_result_buffer #(.W(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sub_add(in_sub_add),
    .in_result(in_result), .in_carry(in_carry), .in_zero(in_zero), .in_overflow(in_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_sub_add(out_sub_add),
    .out_carry(out_carry), .out_zero(out_zero), .out_overflow(out_overflow),
    .out_result(out_result), .count(count), .clear_sticky(clear_sticky),
    .sticky_carry(sticky_carry), .sticky_ovf(sticky_ovf), .ovf_count(ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic sa, input logic c, input logic z,
                        input logic o, input logic [31:0] r);
    in_valid    = v;
    in_sub_add  = sa;
    in_carry    = c;
    in_zero     = z;
    in_overflow = o;
    in_result   = r;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 32'h0);
    out_ready = 1'b0;
    clear_sticky = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    tick;
    checks++; if (count !== 3'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_init: count=%0d in_ready=%b out_valid=%b expected 0/1/0", count, in_ready, out_valid);
    end
    checks++; if (sticky_ovf !== 1'b0 || sticky_carry !== 1'b0 || ovf_count !== 8'd0) begin
      errors++; $display("FAIL reset_sticky: ovf=%b carry=%b cnt=%0d expected 0/0/0", sticky_ovf, sticky_carry, ovf_count);
    end
    set_in(1, 0, 1, 0, 1, 32'hDEAD0001); tick;
    set_in(1, 0, 0, 0, 0, 32'hDEAD0002); tick;
    set_in(0, 0, 0, 0, 0, 32'h0);
    checks++; if (count !== 3'd2 || out_result !== 32'hDEAD0001) begin
      errors++; $display("FAIL reset_prefill: count=%0d head=%h expected 2/dead0001", count, out_result);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || out_result !== 32'h0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_async: count=%0d out_valid=%b result=%h in_ready=%b expected 0/0/0/1",
                         count, out_valid, out_result, in_ready);
    end
    checks++; if (out_carry !== 1'b0 || out_overflow !== 1'b0 || ovf_count !== 8'd0 || sticky_ovf !== 1'b0) begin
      errors++; $display("FAIL reset_async_flags: carry=%b ovf=%b ovf_count=%0d sticky_ovf=%b expected 0", out_carry, out_overflow, ovf_count, sticky_ovf);
    end
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_fill_drain;
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      set_in(1, 0, 0, 0, 0, 32'(i));
      tick;
      if (i == 1) begin
        checks++; if (out_valid !== 1'b1 || out_result !== 32'h1) begin
          errors++; $display("FAIL fwft_latency: out_valid=%b result=%h expected 1/00000001", out_valid, out_result);
        end
      end
    end
    checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin
      errors++; $display("FAIL fill_full: count=%0d in_ready=%b expected 4/0", count, in_ready);
    end
    set_in(1, 0, 0, 0, 0, 32'h5);
    tick;
    set_in(0, 0, 0, 0, 0, 32'h0);
    checks++; if (count !== 3'd4 || out_result !== 32'h1) begin
      errors++; $display("FAIL push_full_dropped: count=%0d head=%h expected 4/00000001", count, out_result);
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (out_valid !== 1'b1 || out_result !== 32'(i)) begin
        errors++; $display("FAIL drain_%0d: out_valid=%b result=%h expected 1/%h", i, out_valid, out_result, 32'(i));
      end
      tick;
      if (i == 1) begin
        checks++; if (in_ready !== 1'b1) begin
          errors++; $display("FAIL ready_after_pop: in_ready=%b expected 1", in_ready);
        end
      end
    end
    checks++; if (out_valid !== 1'b0 || out_result !== 32'h0 || count !== 3'd0) begin
      errors++; $display("FAIL drain_empty: out_valid=%b result=%h count=%0d expected 0/0/0", out_valid, out_result, count);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [31:0] q[$];
    logic [31:0] v;
    out_ready = 1'b0;
    set_in(1, 0, 0, 0, 0, 32'h10); tick;
    set_in(1, 0, 0, 0, 0, 32'h11); tick;
    q.push_back(32'h10);
    q.push_back(32'h11);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v = 32'hA5A5A5A0 + 32'(i);
      set_in(1, 0, 0, 0, 0, v);
      checks++; if (out_result !== q[0]) begin
        errors++; $display("FAIL b2b_order_%0d: result=%h expected %h", i, out_result, q[0]);
      end
      tick;
      void'(q.pop_front());
      q.push_back(v);
      checks++; if (count !== 3'd2) begin
        errors++; $display("FAIL b2b_count_%0d: count=%0d expected 2", i, count);
      end
    end
    set_in(0, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      checks++; if (out_valid !== 1'b1 || out_result !== q[0]) begin
        errors++; $display("FAIL b2b_tail_%0d: out_valid=%b result=%h expected 1/%h", i, out_valid, out_result, q[0]);
      end
      tick;
      void'(q.pop_front());
    end
    checks++; if (out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_empty: out_valid=%b expected 0", out_valid);
    end
    // Push into an empty buffer with out_ready high: the entry must stay.
    set_in(1, 0, 0, 0, 0, 32'h77); tick;
    set_in(0, 0, 0, 0, 0, 32'h0);
    checks++; if (count !== 3'd1 || out_result !== 32'h77) begin
      errors++; $display("FAIL push_empty_ready: count=%0d result=%h expected 1/00000077", count, out_result);
    end
    tick;
    out_ready = 1'b0;
  endtask

  task automatic test_flags;
    out_ready = 1'b0;
    set_in(1, 0, 0, 0, 1, 32'h80000000); tick;
    set_in(1, 1, 1, 1, 0, 32'h00000000); tick;
    set_in(0, 0, 0, 0, 0, 32'h0);
    checks++; if ({out_sub_add, out_carry, out_zero, out_overflow} !== 4'b0001 || out_result !== 32'h80000000) begin
      errors++; $display("FAIL flags_add_ovf: sa/c/z/o=%b%b%b%b result=%h expected 0001/80000000",
                         out_sub_add, out_carry, out_zero, out_overflow, out_result);
    end
    out_ready = 1'b1;
    tick;
    checks++; if ({out_sub_add, out_carry, out_zero, out_overflow} !== 4'b1110 || out_result !== 32'h0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL flags_sub_zero: sa/c/z/o=%b%b%b%b result=%h valid=%b expected 1110/00000000/1",
                         out_sub_add, out_carry, out_zero, out_overflow, out_result, out_valid);
    end
    tick;
    out_ready = 1'b0;
  endtask

  task automatic test_sticky;
    clear_sticky = 1'b1;
    tick;
    clear_sticky = 1'b0;
    checks++; if (sticky_ovf !== 1'b0 || sticky_carry !== 1'b0 || ovf_count !== 8'd0) begin
      errors++; $display("FAIL sticky_clear: ovf=%b carry=%b cnt=%0d expected 0/0/0", sticky_ovf, sticky_carry, ovf_count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      set_in(1, 0, 0, 0, 1, 32'(i));
      tick;
      if (i == 9) begin
        checks++; if (ovf_count !== (STICKY ? 8'd10 : 8'd0)) begin
          errors++; $display("FAIL sticky_count_10: cnt=%0d expected %0d", ovf_count, STICKY ? 10 : 0);
        end
      end
    end
    checks++; if (ovf_count !== (STICKY ? 8'd255 : 8'd0) || sticky_ovf !== STICKY || sticky_carry !== 1'b0) begin
      errors++; $display("FAIL sticky_saturate: cnt=%0d ovf=%b carry=%b expected %0d/%b/0",
                         ovf_count, sticky_ovf, sticky_carry, STICKY ? 255 : 0, STICKY);
    end
    clear_sticky = 1'b1;
    set_in(1, 0, 0, 0, 1, 32'h1);
    tick;
    checks++; if (ovf_count !== (STICKY ? 8'd1 : 8'd0) || sticky_ovf !== STICKY) begin
      errors++; $display("FAIL sticky_clear_push: cnt=%0d ovf=%b expected %0d/%b", ovf_count, sticky_ovf, STICKY ? 1 : 0, STICKY);
    end
    set_in(1, 0, 1, 0, 0, 32'h2);
    tick;
    checks++; if (ovf_count !== 8'd0 || sticky_ovf !== 1'b0 || sticky_carry !== STICKY) begin
      errors++; $display("FAIL sticky_clear_carry: cnt=%0d ovf=%b carry=%b expected 0/0/%b", ovf_count, sticky_ovf, sticky_carry, STICKY);
    end
    clear_sticky = 1'b0;
    set_in(0, 0, 0, 0, 0, 32'h0);
    tick; tick;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset;
    test_fill_drain;
    test_back_to_back;
    test_flags;
    test_sticky;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu32_result_buffer.md
# alu32_result_buffer

Downstream stage of the 32-bit add/sub ALU. It captures each ALU result and its carry, zero and overflow flags with a valid/ready handshake, and holds them in a small first-word-fall-through FIFO. Consumers (display driver, register writeback) drain entries at their own pace. Optionally keeps sticky flags and a saturating overflow counter for the whole run.

## Interface
- `W`, 32: result width.
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: ALU output is valid this cycle.
- `in_ready` out 1: buffer can accept an entry.
- `in_sub_add` in 1: operation that produced the entry (0 add, 1 sub).
- `in_result` in W: ALU result.
- `in_carry`, `in_zero`, `in_overflow` in 1 each: ALU flags.
- `out_valid` out 1: head entry is present.
- `out_ready` in 1: consumer takes the head entry.
- `out_sub_add`, `out_carry`, `out_zero`, `out_overflow` out 1 each: head entry fields.
- `out_result` out W: head entry result.
- `count` out $clog2(DEPTH)+1: occupied entries, 0..DEPTH.
- `clear_sticky` in 1: synchronous clear of the sticky state.
- `sticky_carry`, `sticky_ovf` out 1 each: sticky flags.
- `ovf_count` out 8: saturating count of pushed overflow entries.

## Operation
- Entry is {sub_add, carry, zero, overflow, result}, stored as given; flags are not recomputed.
- Push when `in_valid && in_ready`. Pop when `out_valid && out_ready`.
- `in_ready = (count != DEPTH)`. It depends only on state, never on `out_ready`. There is no pass-through when full.
- `out_valid = (count != 0)`. Out fields show `mem[rd_ptr]` combinationally. When empty, all out fields are forced to 0.
- Read and write pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Push and pop in the same cycle, not full and not empty: both pointers advance and `count` is unchanged.
- Push while empty with `out_ready=1`: the entry is written. It is not popped in that cycle because `out_valid` was 0.
- Full with `in_valid=1`: nothing is written and the upstream holds its data. A pop in that cycle makes `in_ready=1` on the next cycle.
- Pop while empty is ignored. Push while full is ignored.
- Sticky logic (macro enabled) runs on each push:
  - `sticky_ovf |= in_overflow` and `sticky_carry |= in_carry`.
  - `ovf_count` increments when `in_overflow=1` and saturates at 255.
  - `clear_sticky` zeros all three.
  - If `clear_sticky` coincides with a push carrying a flag, the push wins over the clear for that flag. For example, `clear_sticky` with an overflow push gives `sticky_ovf=1`, `ovf_count=1`.

## Timing
- Reset (async assert, sync-to-clk release is the system's job) sets:
  - pointers = 0, `count=0`, `in_ready=1`, `out_valid=0`
  - all out fields = 0
  - `sticky_carry=0`, `sticky_ovf=0`, `ovf_count=0`
- Memory contents are not reset.
- Latency: a push at edge N shows `out_valid=1` with that entry from edge N to N+1. This is 1 cycle, FWFT.
- Throughput: 1 entry per cycle in steady state when not full.
- Reset asserted mid-stream discards all entries immediately, without waiting for a clock edge.
- Sticky outputs update at the push edge.

## Configuration
- `ALU32_RB_STICKY_EN` defined: the sticky flags, `ovf_count` and the `clear_sticky` logic are built as described.
- Not defined:
  - `sticky_carry`, `sticky_ovf` and `ovf_count` are tied to 0, and `clear_sticky` is ignored.
  - The ports remain so instantiations do not change.

## Test plan
- **Reset values:** assert `rst_n=0` mid-cycle with 2 entries held. Expect `count=0`, `out_valid=0`, `out_result=0`, `in_ready=1` immediately, without a clock edge.
- **Fill and drain:** push results 0x1, 0x2, 0x3, 0x4 with `out_ready=0`. Expect `count=4` and `in_ready=0`. A fifth push of 0x5 is dropped. Then hold `out_ready=1`: outputs are 0x1, 0x2, 0x3, 0x4 in order on consecutive cycles, then `out_valid=0`.
- **Simultaneous push/pop:** with `count=2`, push 0xA5A5A5A5 while popping every cycle for 8 cycles. Expect `count` to stay at 2 and order to be preserved across pointer wrap.
- **Flag passthrough:** push {sub_add=0, result=0x80000000, carry=0, zero=0, overflow=1}, as from 0x7FFFFFFF+1. Then push {sub_add=1, result=0, carry=1, zero=1, overflow=0}, as from 5-5. Expect both to pop with identical fields.
- **Sticky (macro on):** push 300 entries with `in_overflow=1`. Expect `ovf_count=255` and `sticky_ovf=1`. Assert `clear_sticky` together with an overflow push. Expect `ovf_count=1` and `sticky_ovf=1`.
- **Sticky (macro off):** same stimulus. Expect `ovf_count=0` and `sticky_ovf=0` throughout.
